// File: rtl/usb_pkt_reader_if.sv
// Byte-stream link from the packet reader to the USB PHY transmitter.
// The master drives data, valid, last and zlp. The slave drives ready.
interface usb_pkt_reader_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;
    logic             m_zlp;

    modport master (output m_data, m_valid, m_last, m_zlp, input m_ready);
    modport slave  (input m_data, m_valid, m_last, m_zlp, output m_ready);
endinterface

// File: rtl/usb_pkt_reader.sv
// Drains whole USB bulk-IN packets from an FWFT FIFO onto a valid/ready byte stream.
// Define USB_RD_ZLP_EN to terminate full-packet transfers with a zero-length packet.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | watch fill level; pick a full packet, a short packet or a ZLP
//  BURST | stream len words, one pop per handshake
//  ZLP   | present a single zero-length beat, no pop
//  GAP   | GAP_CYC dead cycles before the next decision
module usb_pkt_reader #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8192,
    parameter int PKT_SIZE = 512,
    parameter int TIMEOUT  = 1024,
    parameter int GAP_CYC  = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [WIDTH-1:0]  fifo_data,
    input  logic              fifo_empty,
    input  logic [AW:0]       fifo_usedw,
    output logic              fifo_rd_en,
    input  logic              flush,
    usb_pkt_reader_if.master  m,
    output logic              busy
);

    localparam int LW = $clog2(PKT_SIZE) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int GW = $clog2(GAP_CYC) + 1;

    localparam logic [AW:0]   PKT_W  = (AW+1)'(PKT_SIZE);
    localparam logic [LW-1:0] PKT_L  = LW'(PKT_SIZE);
    localparam logic [TW-1:0] TMR_RL = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_RL = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, BURST, ZLP, GAP} state_t;

    state_t         state_q, state_nxt;
    logic [LW-1:0]  len_q, len_nxt;
    logic [LW-1:0]  cnt_q;
    logic [TW-1:0]  tmr_q;
    logic [GW-1:0]  gap_q;
    logic [AW:0]    usedw_q;
    logic           flush_pend_q;

    logic           valid_c, last_c, zlp_c;
    logic           beat, last_beat, zlp_done;
    logic           have_data, full_avail, tmr_tc, gap_tc;
    logic           zlp_go, idle_cnt_en;

    // Idle timer counts down from TIMEOUT-1; reaching zero equals the idle count hitting TIMEOUT-1.
    assign have_data  = (fifo_usedw != '0);
    assign full_avail = (fifo_usedw >= PKT_W);
    assign tmr_tc     = (tmr_q == '0);
    assign gap_tc     = (gap_q == '0);

`ifdef USB_RD_ZLP_EN
    logic full_last_q;

    assign zlp_go      = full_last_q && !have_data && (tmr_tc || flush_pend_q);
    assign idle_cnt_en = have_data || full_last_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            full_last_q <= 1'b0;
        end else if (last_beat) begin
            full_last_q <= (len_q == PKT_L);
        end else if (zlp_done) begin
            full_last_q <= 1'b0;
        end
    end
`else
    assign zlp_go      = 1'b0;
    assign idle_cnt_en = have_data;
`endif

    always_comb begin
        state_nxt  = state_q;
        len_nxt    = len_q;
        valid_c    = 1'b0;
        last_c     = 1'b0;
        zlp_c      = 1'b0;
        beat       = 1'b0;
        last_beat  = 1'b0;
        zlp_done   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (full_avail) begin
                    state_nxt = BURST;
                    len_nxt   = PKT_L;
                end else if (have_data && (tmr_tc || flush_pend_q)) begin
                    state_nxt = BURST;
                    len_nxt   = fifo_usedw[LW-1:0];
                end else if (zlp_go) begin
                    state_nxt = ZLP;
                end
            end
            BURST: begin
                valid_c   = !fifo_empty;
                last_c    = (cnt_q == len_q - 1'b1);
                beat      = valid_c && m.m_ready;
                last_beat = beat && last_c;
                if (last_beat) state_nxt = GAP;
            end
            ZLP: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
`ifdef USB_RD_ZLP_EN
                zlp_c   = 1'b1;
`endif
                if (m.m_ready) begin
                    zlp_done  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP: begin
                if (gap_tc) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            cnt_q        <= '0;
            tmr_q        <= TMR_RL;
            gap_q        <= GAP_RL;
            usedw_q      <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            len_q   <= len_nxt;
            usedw_q <= fifo_usedw;

            if (state_q != BURST) cnt_q <= '0;
            else if (beat)        cnt_q <= cnt_q + 1'b1;

            if (state_q != GAP) gap_q <= GAP_RL;
            else if (!gap_tc)   gap_q <= gap_q - 1'b1;

            // Any fill-level change restarts the idle window.
            if (state_q != IDLE || state_nxt != IDLE || fifo_usedw != usedw_q || !idle_cnt_en)
                tmr_q <= TMR_RL;
            else if (!tmr_tc)
                tmr_q <= tmr_q - 1'b1;

            if (flush)
                flush_pend_q <= 1'b1;
            else if (state_q == IDLE && (state_nxt != IDLE || !have_data))
                flush_pend_q <= 1'b0;
        end
    end

    assign fifo_rd_en = beat;
    assign m.m_data   = fifo_data;
    assign m.m_valid  = valid_c;
    assign m.m_last   = last_c;
    assign m.m_zlp    = zlp_c;
    assign busy       = (state_q != IDLE);

endmodule
